adder_seq_ctrl: RTL
===================

// Module: adder_seq_ctrl
// PURPOSE
//   Sequencer that computes a WIDTH-bit sum by driving one 3-bit ripple-carry
//   adder slice (adder_3bits) over WIDTH/3 cycles, LSB slice first, with a
//   registered inter-slice carry. Trades latency for area; sits between a
//   requesting master (start/done handshake) and the shared slice datapath.
// PARAMETERS
//   WIDTH   12   operand/sum width; multiple of 3, range 3..48 (elab error otherwise)
//   NSLICE  WIDTH/3  derived localparam, number of slice steps; not overridable
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; sampled only in IDLE or DONE
//   abort   in   1      cancel current operation; sampled only in RUN
//   op_a    in   WIDTH  operand A, captured when start is accepted
//   op_b    in   WIDTH  operand B, captured when start is accepted
//   cin     in   1      carry-in, captured when start is accepted
//   busy    out  1      1 while in RUN
//   done    out  1      1-cycle pulse: sum/cout valid
//   sum     out  WIDTH  registered result; holds until next completion
//   cout    out  1      registered carry-out of MSB slice
//   ovf     out  1      signed overflow (only with ADDER_OVF_EN)
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0,
//     step counter=0, carry reg=0, working regs=0. Reset mid-RUN discards op.
//   - FSM: IDLE --start--> RUN; RUN --abort--> IDLE; RUN --last step--> DONE;
//     DONE --start--> RUN (back-to-back); DONE --!start--> IDLE.
//   - Accept edge E0 (start=1 in IDLE/DONE): latch op_a, op_b, carry<=cin, cnt<=0.
//   - Edges E1..E_NSLICE: slice adds op_a/op_b bits [3*cnt+2:3*cnt] + carry;
//     3 result bits written to working reg at that position; carry<=slice cout;
//     cnt++. At E_NSLICE: sum<=working result, cout<=final carry, state<=DONE.
//   - done=1 exactly in the cycle after E_NSLICE; latency start-to-done = NSLICE
//     cycles after E0; throughput one op per NSLICE+1 cycles.
//   - busy=1 for exactly NSLICE cycles (RUN); done and busy never both 1.
//   - start in RUN ignored (no queueing); abort outside RUN ignored.
//   - abort=1 in RUN: next edge -> IDLE, no done, sum/cout/ovf keep previous
//     completed values; abort wins over a same-cycle last step.
//   - Operand inputs changing during RUN have no effect (captured copy used).
//   - Arithmetic modulo 2^WIDTH; {cout,sum} = op_a + op_b + cin exactly.
//   - WIDTH=3: NSLICE=1, single RUN cycle, same FSM.
// CONFIGURATION
//   ADDER_OVF_EN defined: ovf port present; at completion
//     ovf <= carry_into_MSB ^ carry_out_of_MSB (carry_into_MSB = a^b^s at MSB);
//     reset 0, held with sum, unchanged on abort.
//   ADDER_OVF_EN undefined: ovf port and logic absent; all else identical.
// TESTING
//   1 WIDTH=12: op_a=0x0FF, op_b=0x001, cin=0, start 1 cycle -> busy 4 cycles,
//     done pulse at cycle 4 after accept, sum=0x100, cout=0.
//   2 op_a=0xFFF, op_b=0x000, cin=1 -> carry ripples all 4 steps: sum=0x000,
//     cout=1; with ADDER_OVF_EN ovf=0.
//   3 ADDER_OVF_EN: op_a=0x7FF, op_b=0x001, cin=0 -> sum=0x800, cout=0, ovf=1.
//   4 Back-to-back: start held in DONE with new 0x123+0x456 -> RUN next edge,
//     no IDLE cycle, second done 5 cycles after first, sum=0x579.
//   5 abort at RUN step 2 after a prior 0x001+0x001 -> IDLE, no done,
//     sum stays 0x002; start during RUN ignored (no extra done).
//   6 rst_n low mid-RUN (async, off-edge) -> outputs 0 immediately; random
//     op_a/op_b/cin sweep vs {cout,sum}=a+b+cin reference model.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - multi-cycle WIDTH-bit adder driving one shared 3-bit ripple slice
// Optional signed-overflow output is built only when ADDER_OVF_EN is defined.

module adder_3bits (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       ci,
    output logic [2:0] s,
    output logic       co
);
    logic [3:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 3; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[3];
endmodule

module adder_seq_ctrl #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);
    localparam int NSLICE = WIDTH / 3;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % 3) != 0 || WIDTH < 3 || WIDTH > 48) begin : g_bad_width
        $error("adder_seq_ctrl: WIDTH must be a multiple of 3 in 3..48");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                  state;
    logic [NSLICE-1:0][2:0]  a_q;
    logic [NSLICE-1:0][2:0]  b_q;
    logic [NSLICE-1:0][2:0]  res;
    logic [NSLICE-1:0][2:0]  next_res;
    logic                    carry;
    logic [CW-1:0]           cnt;
    logic [2:0]              slice_s;
    logic                    slice_co;
    logic                    last;

    adder_3bits u_slice (
        .a  (a_q[cnt]),
        .b  (b_q[cnt]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    assign last = (cnt == CW'(NSLICE - 1));

    // Working result with the current slice merged in, so the final step can
    // publish the full sum on the same edge it writes the top slice.
    always_comb begin
        next_res      = res;
        next_res[cnt] = slice_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            res   <= '0;
`ifdef ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // Abort takes priority even over the final step.
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        res   <= next_res;
                        carry <= slice_co;
                        cnt   <= cnt + 1'b1;
                        if (last) begin
                            sum   <= next_res;
                            cout  <= slice_co;
`ifdef ADDER_OVF_EN
                            ovf   <= (a_q[NSLICE-1][2] ^ b_q[NSLICE-1][2] ^ next_res[NSLICE-1][2])
                                     ^ slice_co;
`endif
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
